// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between CPU memory stage and data_mem, with load forwarding
//   clk, rst_n                       clock, async active-low reset
//   cpu_address/cpu_write_data       CPU request address and store data
//   cpu_mem_read/cpu_mem_write       CPU load/store requests (both high = store)
//   cpu_read_data                    load result (forwarded or from data_mem)
//   stall                            store refused this cycle (buffer full)
//   buf_empty                        no valid entries
//   mem_address/mem_write_data/mem_read/mem_write/mem_read_data  data_mem port
module store_buffer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic        buf_empty,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [ADDR_BITS-1:0] addr_d [DEPTH];
  logic [31:0]          data_q [DEPTH];
  logic [31:0]          data_d [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 is_load, full, hit, load_miss, drain_en, enq;
  logic [31:0]          hit_data;
  always_comb begin
    is_load = cpu_mem_read && !cpu_mem_write;
    full    = count_q == CW'(DEPTH);
    hit      = 1'b0;
    hit_data = '0;
    // scan oldest to youngest so the last match wins
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == cpu_address[ADDR_BITS-1:0]) begin
        hit      = 1'b1;
        hit_data = data_q[head_q + PW'(i)];
      end
    load_miss = is_load && !hit;
    // store and drain never coincide except when full, where no enqueue happens
    drain_en  = count_q != '0 && !load_miss && (!cpu_mem_write || full);
    enq       = cpu_mem_write && !full;
    stall          = cpu_mem_write && full;
    buf_empty      = count_q == '0;
    mem_read       = load_miss;
    mem_write      = drain_en;
    mem_address    = drain_en ? {{(32-ADDR_BITS){1'b0}}, addr_q[head_q]} : cpu_address;
    mem_write_data = drain_en ? data_q[head_q] : '0;
    cpu_read_data  = !is_load ? '0 : hit ? hit_data : mem_read_data;
    addr_d = addr_q;
    data_d = data_q;
    if (enq) begin
      addr_d[tail_q] = cpu_address[ADDR_BITS-1:0];
      data_d[tail_q] = cpu_write_data;
    end
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    head_d  = drain_en ? head_q + 1'b1 : head_q;
    count_d = enq ? count_q + 1'b1 : drain_en ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer with a behavioural data_mem
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_address = '0, cpu_write_data = '0;
  logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [31:0] cpu_read_data, mem_address, mem_write_data, mem_read_data;
  logic        stall, buf_empty, mem_read, mem_write;
  logic [31:0] mem [65536];
  int          wr_cnt = 0;
  int          tests = 0, fails = 0;
  int          wr_snap;
  always #5 clk = ~clk;
  store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_read_data(cpu_read_data), .stall(stall), .buf_empty(buf_empty),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );
  assign mem_read_data = mem_read ? mem[mem_address[15:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write) begin
      mem[mem_address[15:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_mem_read = rd;
    cpu_mem_write = wr;
    cpu_address = a;
    cpu_write_data = d;
    #1;
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    #2;
    chk("rst_buf_empty", 32'(buf_empty), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    // 1: store then idle drain, then load miss reads back from memory
    drive(0, 1, 2, 32'h0000FFFF);
    chk("t1_enq_mem_write", 32'(mem_write), 0);
    chk("t1_enq_stall", 32'(stall), 0);
    cyc();
    drive(0, 0, 0, 0);
    chk("t1_not_empty", 32'(buf_empty), 0);
    chk("t1_drain_we", 32'(mem_write), 1);
    chk("t1_drain_addr", mem_address, 2);
    chk("t1_drain_data", mem_write_data, 32'h0000FFFF);
    cyc();
    chk("t1_empty", 32'(buf_empty), 1);
    drive(1, 0, 2, 0);
    chk("t1_ld_mem_read", 32'(mem_read), 1);
    chk("t1_ld_data", cpu_read_data, 32'h0000FFFF);
    cyc();
    // 2: load hit on the entry draining the same cycle
    drive(0, 1, 5, 1);
    cyc();
    drive(1, 0, 5, 0);
    chk("t2_fwd_data", cpu_read_data, 1);
    chk("t2_mem_read", 32'(mem_read), 0);
    chk("t2_drain_we", 32'(mem_write), 1);
    chk("t2_drain_addr", mem_address, 5);
    cyc();
    drive(0, 0, 0, 0);
    chk("t2_empty", 32'(buf_empty), 1);
    // 3: duplicate addresses, youngest forwarded, youngest left in memory
    drive(0, 1, 7, 32'hA);
    cyc();
    drive(0, 1, 7, 32'hB);
    chk("t3_no_drain_on_store", 32'(mem_write), 0);
    cyc();
    drive(1, 0, 7, 0);
    chk("t3_fwd_youngest", cpu_read_data, 32'hB);
    chk("t3_drain_old", mem_write_data, 32'hA);
    cyc();
    chk("t3_fwd_again", cpu_read_data, 32'hB);
    chk("t3_drain_new", mem_write_data, 32'hB);
    cyc();
    drive(1, 0, 7, 0);
    chk("t3_empty", 32'(buf_empty), 1);
    chk("t3_mem_data", cpu_read_data, 32'hB);
    cyc();
    // 4: fill, full-store stall with forced drain, then drain in order
    for (int a = 10; a <= 13; a++) begin
      drive(0, 1, 32'(a), 32'h100 + 32'(a));
      chk("t4_fill_stall", 32'(stall), 0);
      cyc();
    end
    drive(0, 1, 14, 32'h10E);
    chk("t4_full_stall", 32'(stall), 1);
    chk("t4_forced_we", 32'(mem_write), 1);
    chk("t4_forced_addr", mem_address, 10);
    cyc();
    chk("t4_accept_stall", 32'(stall), 0);
    chk("t4_accept_we", 32'(mem_write), 0);
    cyc();
    drive(0, 0, 0, 0);
    for (int a = 11; a <= 14; a++) begin
      chk("t4_drain_addr", mem_address, 32'(a));
      cyc();
    end
    chk("t4_empty", 32'(buf_empty), 1);
    for (int a = 10; a <= 14; a++) chk("t4_mem", mem[a], 32'h100 + 32'(a));
    // 5: load miss with two entries queued blocks the drain
    drive(0, 1, 20, 32'h55);
    cyc();
    drive(0, 1, 21, 32'h66);
    cyc();
    drive(1, 0, 32'h000B, 0);
    chk("t5_mem_read", 32'(mem_read), 1);
    chk("t5_mem_write", 32'(mem_write), 0);
    chk("t5_mem_addr", mem_address, 32'h000B);
    chk("t5_ld_data", cpu_read_data, 32'h10B);
    cyc();
    drive(0, 0, 0, 0);
    chk("t5_head_kept", mem_address, 20);
    chk("t5_head_we", 32'(mem_write), 1);
    cyc();
    chk("t5_second", mem_address, 21);
    cyc();
    chk("t5_empty", 32'(buf_empty), 1);
    // 6: async reset mid-cycle with three entries queued
    for (int a = 30; a <= 32; a++) begin
      drive(0, 1, 32'(a), 32'h200 + 32'(a));
      cyc();
    end
    drive(0, 0, 0, 0);
    chk("t6_pre_we", 32'(mem_write), 1);
    wr_snap = wr_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(buf_empty), 1);
    chk("t6_rst_we", 32'(mem_write), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t6_no_writes", 32'(wr_cnt), 32'(wr_snap));
    chk("t6_mem30", mem[30], 0);
    chk("t6_still_empty", 32'(buf_empty), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU memory-stage signals and data_mem.
- Queues CPU stores in a DEPTH-entry FIFO and serves loads, forwarding buffered data on an address hit.
- Drains queued stores into data_mem in program order on cycles the memory port is free.
- data_mem: word-addressed, synchronous write on posedge clk, combinational read gated by mem_read, address bits [15:0] only.

Parameters:
DEPTH, 4, number of buffer entries (power of two, >=2)
ADDR_BITS, 16, low address bits used for matching and storage (matches data_mem depth)

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
cpu_address  input  32  word address from memory stage
cpu_write_data  input  32  store data
cpu_mem_read  input  1  load request
cpu_mem_write  input  1  store request
cpu_read_data  output  32  load result, combinational
stall  output  1  store not accepted this cycle; CPU holds request
buf_empty  output  1  no valid entries (fence/flush indicator)
mem_address  output  32  to data_mem address
mem_write_data  output  32  to data_mem write_data
mem_read  output  1  to data_mem mem_read
mem_write  output  1  to data_mem mem_write
mem_read_data  input  32  from data_mem read_data

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid; head=tail=count=0.
  - buf_empty=1, stall=0, mem_write=0, mem_write_data=0.
  - Pending stores are discarded, including a reset asserted mid-drain.
- Entry = {addr[ADDR_BITS-1:0], data[31:0]}. FIFO order is program order.
- Both cpu_mem_read and cpu_mem_write high: treated as a store only; cpu_read_data=0.
- Load (cpu_mem_read=1, cpu_mem_write=0):
  - Hit (any valid entry with addr == cpu_address[ADDR_BITS-1:0]):
    - cpu_read_data = data of the youngest matching entry.
    - mem_read=0; same-cycle (0-latency) result.
  - Miss:
    - mem_read=1, mem_address=cpu_address, cpu_read_data=mem_read_data.
    - No drain this cycle.
- No load: cpu_read_data=0 and mem_read=0.
- drain_en = (count>0) && !load_miss && (!cpu_mem_write || count==DEPTH).
  - In other words, a drain happens on idle cycles, on load-hit cycles, and on forced full-store cycles.
  - When drain_en=1:
    - mem_write=1, mem_address={zero-extended head addr}, mem_write_data=head data.
    - Head pops at that posedge; data_mem captures the store on the same edge.
  - When drain_en=0: mem_write=0.
  - mem_address muxing: head addr when draining, else cpu_address.
- Store:
  - Not full: enqueue at tail on the posedge; stall=0; no drain that cycle.
  - Full (count==DEPTH):
    - stall=1 and the forced drain pops the head; the store is not enqueued.
    - Next cycle count=DEPTH-1, the held store enqueues, stall=0.
    - Exactly one stall cycle per full-store.
- Duplicate addresses are not coalesced.
  - Each store gets its own entry; in-order drain leaves the youngest value in memory.
  - Forwarding picks the youngest entry.
- Load hit on the entry draining the same cycle forwards the pre-pop data (correct value).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; never enqueue when full, never pop when empty.
- buf_empty = (count==0), combinational from state.

Test Plan:
1. Reset, store addr 2 data 0x0000FFFF, then idle -> enqueue cycle mem_write=0; next cycle mem_write=1, mem_address=2; after edge buf_empty=1, and a later load addr 2 returns 0x0000FFFF with mem_read=1.
2. Store addr 5 data 1, immediately load addr 5 -> cpu_read_data=1, mem_read=0, and that cycle drains addr 5 (mem_write=1).
3. Store addr 7 data 0xA, store addr 7 data 0xB, load addr 7 -> cpu_read_data=0xB. After full drain, memory addr 7 = 0xB.
4. Four stores (addrs 10..13) back-to-back, then a fifth store addr 14 -> stall=1 for one cycle with addr 10 drained, then accepted. After idle drain, memory holds 10..14 in order.
5. Load miss to addr 0x000B while count=2 -> mem_read=1, mem_write=0, count unchanged. Next idle cycle drains.
6. Assert rst_n=0 asynchronously with 3 entries queued, mid-cycle -> buf_empty=1 and mem_write=0 immediately; no further writes reach data_mem.
